cam_tcam_reg: RTL

- Parametrised ternary CAM built from flip-flops; the register-based successor to the team's SRL-based binary CAM.
- Adds per-entry care masks, valid tracking, a one-command clear-all sweep, a compare-valid pipeline with fixed latency, and free-slot reporting.
- Sits beside the flow/lookup tables as the exact-or-wildcard match engine.

---
 rtl/cam_tcam_reg.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cam_tcam_reg.sv
// Flip-flop ternary CAM with per-entry care masks, clear-all sweep, a
// two-stage compare pipeline and lowest-free-slot reporting.
module cam_tcam_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int TERNARY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] write_mask,
  input  logic [1:0]            write_op,
  input  logic                  write_enable,
  output logic                  write_busy,
  input  logic [DATA_WIDTH-1:0] compare_data,
  input  logic                  compare_valid,
  output logic                  match_valid,
  output logic                  match,
  output logic                  match_single,
  output logic                  match_many,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic [ADDR_WIDTH-1:0] free_addr,
  output logic                  full
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int          CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_DELETE = 2'b01,
    OP_NOP    = 2'b10,
    OP_CLEAR  = 2'b11
  } op_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [DEPTH-1:0]      valid;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] mask_q [DEPTH];

  logic [DEPTH-1:0]      hit;
  logic [DEPTH-1:0]      hit_q;
  logic                  cv_q;

  logic [ADDR_WIDTH-1:0] enc_addr;
  logic [CW-1:0]         pop;
  logic [ADDR_WIDTH-1:0] free_nxt;

  // Table storage, valid tracking and clear-all sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      write_busy <= 1'b0;
      valid      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (write_enable) begin
            case (write_op)
              OP_WRITE: begin
                data_q[write_addr] <= write_data;
                mask_q[write_addr] <= (TERNARY != 0) ? write_mask : '1;
                valid[write_addr]  <= 1'b1;
              end
              OP_DELETE: valid[write_addr] <= 1'b0;
              OP_CLEAR: begin
                state      <= SWEEP;
                sweep_cnt  <= '0;
                write_busy <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        SWEEP: begin
          valid[sweep_cnt] <= 1'b0;
          sweep_cnt        <= sweep_cnt + 1'b1;
          if (&sweep_cnt) begin
            state      <= IDLE;
            write_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      hit[i] = valid[i] && (((compare_data ^ data_q[i]) & mask_q[i]) == '0);
  end

  // Stage-2 decode works on the registered hit vector, which is zeroed when
  // no compare was issued so the outputs fall to 0 without extra gating.
  always_comb begin
    enc_addr = '0;
    pop      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (hit_q[i] && (pop == '0))
        enc_addr = ADDR_WIDTH'(i);
      pop = pop + CW'(hit_q[i]);
    end
  end

  always_comb begin
    free_nxt = '0;
    for (int unsigned i = DEPTH; i > 0; i--)
      if (!valid[i-1])
        free_nxt = ADDR_WIDTH'(i - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q        <= '0;
      cv_q         <= 1'b0;
      match_valid  <= 1'b0;
      match        <= 1'b0;
      match_single <= 1'b0;
      match_many   <= 1'b0;
      match_addr   <= '0;
      free_addr    <= '0;
      full         <= 1'b0;
    end else begin
      hit_q        <= compare_valid ? hit : '0;
      cv_q         <= compare_valid;
      match_valid  <= cv_q;
      match        <= (pop != '0);
      match_single <= (pop == CW'(1));
      match_many   <= (pop >  CW'(1));
      match_addr   <= enc_addr;
      free_addr    <= free_nxt;
      full         <= &valid;
    end
  end

endmodule
